// File: rtl/reducer_pkg.sv
// ---------------------------------------------------------------------------
// reducer_pkg
// Shared definitions for the BRAM result reducer:
//   - state_t        : FSM state encoding (S_IDLE / S_RUN / S_DONE)
//   - DEF_*          : default parameter values used by result_reducer_bram
//                      and reducer_rd_ctrl
// ---------------------------------------------------------------------------
package reducer_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    localparam int DEF_CNT_BIT   = 31;
    localparam int DEF_DWIDTH    = 32;
    localparam int DEF_AWIDTH    = 12;
    localparam int DEF_MEM_SIZE  = 4096;
    localparam int DEF_ACC_WIDTH = 32;

endpackage

// File: rtl/reducer_rd_ctrl.sv
// ---------------------------------------------------------------------------
// reducer_rd_ctrl
// Read-address generator and one-stage valid pipeline for the reducer.
// While run is high it issues one BRAM read per cycle (addresses 0,1,2,...)
// until count reads have been issued. valid follows ce by exactly one cycle,
// matching the BRAM read latency, so the consumer knows when q is meaningful.
//
// Ports:
//   clk, reset_n  : clock, asynchronous active-low reset
//   start         : one-cycle pulse on the cycle a run is accepted; clears
//                   the read counter and the valid stage
//   run           : high while the reducer is in S_RUN
//   count         : clamped number of words to read (AWIDTH+1 bits)
//   addr          : BRAM read address (0 when no read is issued)
//   ce            : BRAM chip enable
//   valid         : BRAM data for the previous ce is present this cycle
// ---------------------------------------------------------------------------
module reducer_rd_ctrl
    import reducer_pkg::*;
#(
    parameter int AWIDTH = DEF_AWIDTH
)(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic              run,
    input  logic [AWIDTH:0]   count,
    output logic [AWIDTH-1:0] addr,
    output logic              ce,
    output logic              valid
);

    // One extra bit so the counter can reach a full MEM_SIZE count.
    logic [AWIDTH:0] rd_cnt_r;
    logic            valid_r;
    logic            ce_s;

    // Issue a read whenever the run is active and reads remain.
    always_comb begin
        ce_s = 1'b0;
        if (run && (rd_cnt_r < count)) begin
            ce_s = 1'b1;
        end else begin
            ce_s = 1'b0;
        end
    end

    // Read counter and valid stage; valid mirrors ce delayed by one cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_cnt_r <= {(AWIDTH+1){1'b0}};
            valid_r  <= 1'b0;
        end else if (start) begin
            rd_cnt_r <= {(AWIDTH+1){1'b0}};
            valid_r  <= 1'b0;
        end else begin
            valid_r <= ce_s;
            if (ce_s) begin
                rd_cnt_r <= rd_cnt_r + {{AWIDTH{1'b0}}, 1'b1};
            end
        end
    end

    assign ce    = ce_s;
    assign addr  = ce_s ? rd_cnt_r[AWIDTH-1:0] : {AWIDTH{1'b0}};
    assign valid = valid_r;

endmodule

// File: rtl/result_reducer_bram.sv
// ---------------------------------------------------------------------------
// result_reducer_bram
// Streams i_num_cnt words (clamped to MEM_SIZE) out of a BRAM, where each
// word packs two unsigned DWIDTH/2-bit products {r0, r1} (r0 in the upper
// half), and reduces them into running sums (and optionally maxima).
//
// Optional feature: define REDUCER_MAX_EN to build running unsigned maxima
// of r0 / r1 on o_max_0 / o_max_1. Without it both outputs are tied to 0.
//
// Ports:
//   clk, reset_n   : clock, asynchronous active-low reset
//   i_run          : start pulse, honoured only in S_IDLE
//   i_num_cnt      : number of words to reduce
//   o_idle/o_read  : high in S_IDLE / S_RUN
//   o_done         : one-cycle pulse in S_DONE
//   addr_b1, ce_b1, we_b1, q_b1 : BRAM read port (we_b1 always 0,
//                    q_b1 valid one cycle after ce_b1)
//   o_sum_0/1      : sum of r0 / r1, wrapping at ACC_WIDTH
//   o_sum_total    : o_sum_0 + o_sum_1, wrapping at ACC_WIDTH
//   o_max_0/1      : maximum r0 / r1 (REDUCER_MAX_EN only)
// Results are cleared when a run is accepted and then held from S_DONE
// until the next accepted i_run.
// ---------------------------------------------------------------------------
module result_reducer_bram
    import reducer_pkg::*;
#(
    parameter int CNT_BIT   = DEF_CNT_BIT,
    parameter int DWIDTH    = DEF_DWIDTH,
    parameter int AWIDTH    = DEF_AWIDTH,
    parameter int MEM_SIZE  = DEF_MEM_SIZE,
    parameter int ACC_WIDTH = DEF_ACC_WIDTH
)(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_run,
    input  logic [CNT_BIT-1:0]    i_num_cnt,
    output logic                  o_idle,
    output logic                  o_read,
    output logic                  o_done,
    output logic [AWIDTH-1:0]     addr_b1,
    output logic                  ce_b1,
    output logic                  we_b1,
    input  logic [DWIDTH-1:0]     q_b1,
    output logic [ACC_WIDTH-1:0]  o_sum_0,
    output logic [ACC_WIDTH-1:0]  o_sum_1,
    output logic [ACC_WIDTH-1:0]  o_sum_total,
    output logic [DWIDTH/2-1:0]   o_max_0,
    output logic [DWIDTH/2-1:0]   o_max_1
);

    localparam int HW = DWIDTH / 2;
    localparam int CW = AWIDTH + 1;
    localparam logic [CNT_BIT-1:0] MEM_SIZE_LIM = CNT_BIT'(MEM_SIZE);
    localparam logic [CW-1:0]      MEM_SIZE_CW  = CW'(MEM_SIZE);

    state_t               state_r;
    state_t               state_nx_s;
    logic                 start_s;
    logic                 run_s;
    logic                 valid_s;
    logic [CW-1:0]        cnt_clamp_s;
    logic [CW-1:0]        cnt_r;
    logic [CW-1:0]        acc_cnt_r;
    logic [HW-1:0]        r0_s;
    logic [HW-1:0]        r1_s;
    logic [ACC_WIDTH-1:0] sum0_r;
    logic [ACC_WIDTH-1:0] sum1_r;
    logic [ACC_WIDTH-1:0] total_r;

    assign start_s = (state_r == S_IDLE) && i_run;
    assign run_s   = (state_r == S_RUN);
    assign r0_s    = q_b1[DWIDTH-1:HW];
    assign r1_s    = q_b1[HW-1:0];

    // Clamp the requested word count to the BRAM depth.
    always_comb begin
        cnt_clamp_s = {CW{1'b0}};
        if (i_num_cnt > MEM_SIZE_LIM) begin
            cnt_clamp_s = MEM_SIZE_CW;
        end else begin
            cnt_clamp_s = CW'(i_num_cnt);
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next state: the run ends once every requested word has been
    // accumulated, which also covers a zero count on the first RUN cycle.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (i_run) begin
                    state_nx_s = S_RUN;
                end else begin
                    state_nx_s = S_IDLE;
                end
            end
            S_RUN: begin
                if (acc_cnt_r == cnt_r) begin
                    state_nx_s = S_DONE;
                end else begin
                    state_nx_s = S_RUN;
                end
            end
            S_DONE:  state_nx_s = S_IDLE;
            default: state_nx_s = S_IDLE;
        endcase
    end

    assign o_idle = (state_r == S_IDLE);
    assign o_read = (state_r == S_RUN);
    assign o_done = (state_r == S_DONE);
    assign we_b1  = 1'b0;

    reducer_rd_ctrl #(
        .AWIDTH (AWIDTH)
    ) u_rd_ctrl (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start_s),
        .run     (run_s),
        .count   (cnt_r),
        .addr    (addr_b1),
        .ce      (ce_b1),
        .valid   (valid_s)
    );

    // Count latch and sum accumulation; cleared when a run is accepted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r     <= {CW{1'b0}};
            acc_cnt_r <= {CW{1'b0}};
            sum0_r    <= {ACC_WIDTH{1'b0}};
            sum1_r    <= {ACC_WIDTH{1'b0}};
            total_r   <= {ACC_WIDTH{1'b0}};
        end else if (start_s) begin
            cnt_r     <= cnt_clamp_s;
            acc_cnt_r <= {CW{1'b0}};
            sum0_r    <= {ACC_WIDTH{1'b0}};
            sum1_r    <= {ACC_WIDTH{1'b0}};
            total_r   <= {ACC_WIDTH{1'b0}};
        end else if (valid_s) begin
            acc_cnt_r <= acc_cnt_r + CW'(1'b1);
            sum0_r    <= sum0_r + ACC_WIDTH'(r0_s);
            sum1_r    <= sum1_r + ACC_WIDTH'(r1_s);
            total_r   <= total_r + ACC_WIDTH'(r0_s) + ACC_WIDTH'(r1_s);
        end
    end

    assign o_sum_0     = sum0_r;
    assign o_sum_1     = sum1_r;
    assign o_sum_total = total_r;

`ifdef REDUCER_MAX_EN
    logic [HW-1:0] max0_r;
    logic [HW-1:0] max1_r;

    // Running unsigned maxima of each half, cleared when a run is accepted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            max0_r <= {HW{1'b0}};
            max1_r <= {HW{1'b0}};
        end else if (start_s) begin
            max0_r <= {HW{1'b0}};
            max1_r <= {HW{1'b0}};
        end else if (valid_s) begin
            if (r0_s > max0_r) begin
                max0_r <= r0_s;
            end
            if (r1_s > max1_r) begin
                max1_r <= r1_s;
            end
        end
    end

    assign o_max_0 = max0_r;
    assign o_max_1 = max1_r;
`else
    assign o_max_0 = {HW{1'b0}};
    assign o_max_1 = {HW{1'b0}};
`endif

endmodule
